// File: rtl/muldiv_if.sv
// Handshake and data bundle between the EX-stage pipeline and the multiply/divide sequencer.
`timescale 1ns/1ps
interface muldiv_if #(parameter int WIDTH = 32) ();
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, funct3, a, b, abort,
                  input  stall, busy, done, result);
  modport slave  (input  start, funct3, a, b, abort,
                  output stall, busy, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: radix-2 shift-add and restoring divide on magnitudes,
// sign fix-up in one extra cycle, fast path for divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for an M-extension op
// CALC  | WIDTH iterations of shift-add or restoring divide
// FIX   | sign correction / word select / special result, result loaded on exit
// DONE  | done pulse, pipeline released
`timescale 1ns/1ps
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [2:0]       op;
  logic             neg_q, neg_r, spec_div0, spec_ovf;
  logic [WIDTH-1:0] a_raw, mcand, acc_lo, result_q;
  logic [WIDTH:0]   acc_hi;

  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div0, ovf, special, launch, last_iter;

  always_comb begin
    a_signed = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b101) && (bus.funct3 != 3'b111);
    b_signed = a_signed && (bus.funct3 != 3'b010);
    a_neg    = a_signed & bus.a[WIDTH-1];
    b_neg    = b_signed & bus.b[WIDTH-1];
    a_mag    = a_neg ? -bus.a : bus.a;
    b_mag    = b_neg ? -bus.b : bus.b;
    div0     = bus.funct3[2] && (bus.b == '0);
    ovf      = bus.funct3[2] && !bus.funct3[0] && (bus.a == MIN_NEG) && (bus.b == '1);
    special  = div0 | ovf;
  end

  assign launch    = (state == IDLE) && bus.start && !bus.abort;
  assign last_iter = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = special ? FIX : CALC;
      CALC:    if (bus.abort) state_nxt = IDLE;
               else if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = bus.abort ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration; acc_lo holds the multiplier (mul) or the dividend/quotient (div).
  logic [WIDTH:0]   mul_sum, div_trial, step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, mcand} : '0);
    div_trial = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]} - {1'b0, mcand};
    if (!op[2]) begin
      step_hi = {1'b0, mul_sum[WIDTH:1]};
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (!div_trial[WIDTH]) begin
      step_hi = {1'b0, div_trial[WIDTH-1:0]};
      step_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = {1'b0, acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
      step_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_val;

  always_comb begin
    prod = {acc_hi[WIDTH-1:0], acc_lo};
    if (neg_q) prod = -prod;
    quo = neg_q ? -acc_lo : acc_lo;
    rem = neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    case (op)
      3'b000:                 fix_val = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_val = quo;
      default:                fix_val = rem;
    endcase
    // op[1] separates REM/REMU from DIV/DIVU
    if (spec_div0)     fix_val = op[1] ? a_raw : '1;
    else if (spec_ovf) fix_val = op[1] ? '0 : MIN_NEG;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count     <= '0;
      op        <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      spec_div0 <= 1'b0;
      spec_ovf  <= 1'b0;
      a_raw     <= '0;
      mcand     <= '0;
      acc_lo    <= '0;
      acc_hi    <= '0;
      result_q  <= '0;
    end else begin
      case (state)
        IDLE: if (launch) begin
          op        <= bus.funct3;
          a_raw     <= bus.a;
          mcand     <= b_mag;
          acc_lo    <= a_mag;
          acc_hi    <= '0;
          neg_q     <= a_neg ^ b_neg;
          neg_r     <= a_neg;
          spec_div0 <= div0;
          spec_ovf  <= ovf;
          count     <= '0;
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + CW'(1);
        end
        FIX:     if (!bus.abort) result_q <= fix_val;
        default: ;
      endcase
    end
  end

  assign bus.stall  = launch || (state == CALC) || (state == FIX);
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer. It sits beside the single-cycle ALU in the EX stage of the sail-core pipeline.
- It accepts one M-extension operation, stalls the pipeline while it runs a fixed radix-2 shift-add / restoring-divide loop, then presents a registered result for one cycle.
- It also handles RISC-V divide-by-zero and signed-overflow cases in a short fast path.

Parameters:
WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
start  in  1  M-extension op valid in EX (held by the pipeline while stall=1)
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
A  in  WIDTH  rs1 operand (forwarded value)
B  in  WIDTH  rs2 operand (forwarded value)
abort  in  1  pipeline flush; kills the operation in flight
stall  out  1  hold the pipeline (combinational)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse; result valid
result  out  WIDTH  registered result

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, count=0, result=0, done=0, busy=0.
  - Internal accumulator and remainder registers are cleared.
  - Reset overrides every other input, including mid-operation.
- States and transitions:
  - IDLE → CALC: start=1 and abort=0, normal case. Operands, funct3 and sign flags are captured on this edge; later A/B changes are ignored.
  - IDLE → FIX: start=1 and abort=0, special case:
    - divisor zero, for DIV/DIVU/REM/REMU; or
    - DIV/REM with A=0x80000000 and B=0xFFFFFFFF.
  - CALC: runs exactly WIDTH cycles, count 0..WIDTH-1.
    - MUL*: shift-add on magnitudes.
    - DIV*/REM*: restoring division on magnitudes.
    - CALC → FIX when count=WIDTH-1.
  - FIX: one cycle. Applies sign correction, selects the low/high product word or quotient/remainder, and loads result at its exit edge. FIX → DONE.
  - DONE: done=1 for one cycle, stall=0 so the pipeline advances. DONE → IDLE unconditionally; start is ignored in DONE because it still belongs to the retiring instruction.
- Latency, with the start cycle numbered 0:
  - Normal: CALC cycles 1..32, FIX cycle 33, done=1 in cycle 34.
  - Special: FIX cycle 1, done=1 in cycle 2.
- stall = (state==IDLE & start & ~abort) | state==CALC | state==FIX.
- Sign rules:
  - MUL/MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A); a zero remainder stays 0.
  - MUL returns product[31:0]; MULH* return product[63:32].
- Special results:
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → A.
  - Signed overflow: DIV → 0x80000000; REM → 0.
- abort:
  - In CALC or FIX: state → IDLE next edge; no done; result keeps its previous value.
  - In IDLE with start=1: abort wins, nothing is captured.
  - In DONE: no effect, since the result is already out.
- result holds its value until the next FIX exit edge; it is not cleared by a new start.
- WIDTH not equal to 32: behaviour is identical. Latency becomes WIDTH+2, and the overflow constant becomes the most-negative WIDTH-bit value.

Test Plan:
- Basic multiply:
  - MUL A=7, B=0xFFFFFFFD (−3), start at cycle 0 → stall=1 in cycles 0..33, done=1 only in cycle 34, result=0xFFFFFFEB.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- High-word multiply variants:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV A=0xFFFFFFF9 (−7), B=2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF. Both have done in cycle 34.
- Fast path:
  - DIVU 5/0 → 0xFFFFFFFF with done in cycle 2.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
  - stall=0 in cycle 2 for all of these.
- Abort:
  - MUL 3×4 completes → result=12.
  - Start DIVU 100/7 at cycle 0, abort=1 in cycle 10 → IDLE in cycle 11, no done pulse, result stays 12, busy=0.
- Reset and back-to-back:
  - rst=0 in cycle 20 of a MULHU → all outputs 0 next cycle.
  - Then start DIVU 100/7 → result 14, done cycle 34; start REMU 100/7 in the following cycle → result 2, done 34 cycles after its own start.
